// File: rtl/flux_rr_scheduler.sv
// Round-robin flux scheduler for a shared multi-flux actor.
// Holds one flux for a bounded burst of tokens, then hands over without a bubble.
module flux_rr_scheduler #(
  parameter int FLUX      = 2,
  parameter int QUANTUM   = 8,
  parameter int STALL_MAX = 4,
  parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FLUX-1:0]               req_i,
  input  logic                          fire_i,
  input  logic                          release_i,
  output logic [FLUX-1:0]               grant_o,
  output logic                          grant_valid_o,
  output logic [TAG_WIDTH-1:0]          grant_tag_o,
  output logic [$clog2(QUANTUM+1)-1:0]  burst_cnt_o
);

  localparam int BW = $clog2(QUANTUM + 1);
  localparam int IW = $clog2(STALL_MAX + 1);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t               state_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [TAG_WIDTH-1:0] last_q;
  logic [BW-1:0]        burst_q;
  logic [IW-1:0]        idle_q;
  logic [FLUX-1:0]      grant_q;
  logic                 grant_valid_q;

  logic [TAG_WIDTH-1:0] ptr_d;
  logic [TAG_WIDTH-1:0] cand_idx [FLUX];
  logic [FLUX-1:0]      hit_d;
  logic                 found_d;
  logic [TAG_WIDTH-1:0] pick_d;
  logic [FLUX-1:0]      pick_oh_d;
  logic                 end_d;

  // In LOCK the current tag is the pointer, so it ranks last in the search.
  assign ptr_d = (state_q == IDLE) ? last_q : tag_q;

  // Candidate gi is the flux at search offset gi+1 from the pointer.
  for (genvar gi = 0; gi < FLUX; gi++) begin : g_cand
    assign cand_idx[gi] = TAG_WIDTH'((int'(ptr_d) + gi + 1) % FLUX);
    assign hit_d[gi]    = req_i[cand_idx[gi]];
  end

  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    for (int k = FLUX - 1; k >= 0; k--) begin
      if (hit_d[k]) begin
        found_d = 1'b1;
        pick_d  = cand_idx[k];
      end
    end
  end

  always_comb begin
    pick_oh_d         = '0;
    pick_oh_d[pick_d] = 1'b1;
  end

  assign end_d = release_i
               | (fire_i && (burst_q == BW'(QUANTUM - 1)))
               | (!fire_i && !req_i[tag_q] && (idle_q == IW'(STALL_MAX - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      last_q        <= TAG_WIDTH'(FLUX - 1);
      burst_q       <= '0;
      idle_q        <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q       <= LOCK;
            tag_q         <= pick_d;
            grant_q       <= pick_oh_d;
            grant_valid_q <= 1'b1;
            burst_q       <= '0;
            idle_q        <= '0;
          end
        end
        LOCK: begin
          if (end_d) begin
            // A fire in this cycle belongs to the outgoing flux; counters restart.
            last_q  <= tag_q;
            burst_q <= '0;
            idle_q  <= '0;
            if (found_d) begin
              tag_q   <= pick_d;
              grant_q <= pick_oh_d;
            end else begin
              state_q       <= IDLE;
              grant_q       <= '0;
              grant_valid_q <= 1'b0;
            end
          end else begin
            if (fire_i) begin
              burst_q <= burst_q + 1'b1;
            end
            if (fire_i || req_i[tag_q]) begin
              idle_q <= '0;
            end else if (idle_q != IW'(STALL_MAX)) begin
              idle_q <= idle_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_tag_o   = tag_q;
  assign burst_cnt_o   = burst_q;

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Directed checks of flux_rr_scheduler: a 2-flux and a 3-flux instance, QUANTUM=4, STALL_MAX=4.
module tb_flux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req2;
  logic       fire2, rel2;
  logic [1:0] grant2;
  logic       gv2;
  logic [0:0] tag2;
  logic [2:0] burst2;
  logic [2:0] req3;
  logic       fire3, rel3;
  logic [2:0] grant3;
  logic       gv3;
  logic [1:0] tag3;
  logic [2:0] burst3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flux_rr_scheduler #(.FLUX(2), .QUANTUM(4), .STALL_MAX(4)) dut2 (
    .clk(clk), .rst(rst), .req_i(req2), .fire_i(fire2), .release_i(rel2),
    .grant_o(grant2), .grant_valid_o(gv2), .grant_tag_o(tag2), .burst_cnt_o(burst2)
  );

  flux_rr_scheduler #(.FLUX(3), .QUANTUM(4), .STALL_MAX(4)) dut3 (
    .clk(clk), .rst(rst), .req_i(req3), .fire_i(fire3), .release_i(rel3),
    .grant_o(grant3), .grant_valid_o(gv3), .grant_tag_o(tag3), .burst_cnt_o(burst3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req2 = 2'b11; fire2 = 1'b0; rel2 = 1'b0;
    req3 = 3'b000; fire3 = 1'b0; rel3 = 1'b0;
    tick(); tick();
    check_eq("rst_grant", 32'(grant2), 32'h0);
    check_eq("rst_gv",    32'(gv2),    32'h0);
    check_eq("rst_tag",   32'(tag2),   32'h0);
    check_eq("rst_burst", 32'(burst2), 32'h0);
    check_eq("rst3_grant", 32'(grant3), 32'h0);

    // First grant after reset
    rst = 1'b0; req2 = 2'b10;
    tick();
    check_eq("first_grant", 32'(grant2), 32'h2);
    check_eq("first_gv",    32'(gv2),    32'h1);
    check_eq("first_tag",   32'(tag2),   32'h1);

    // Quantum rotation: alternate every 4 fires, burst 0..3
    req2 = 2'b11; fire2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq($sformatf("rot_burst%0d", i), 32'(burst2), 32'((i + 1) % 4));
      check_eq($sformatf("rot_grant%0d", i), 32'(grant2),
               ((((i + 1) / 4) % 2) == 0) ? 32'h2 : 32'h1);
    end

    // Sole requester keeps flux0, burst wraps 3->0
    req2 = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("sole_grant%0d", i), 32'(grant2), 32'h1);
      check_eq($sformatf("sole_burst%0d", i), 32'(burst2), 32'((i + 1) % 4));
    end

    // Stall timeout: flux0 idle, flux1 waiting
    req2 = 2'b10; fire2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_hold%0d", i), 32'(grant2), 32'h1);
    end
    check_eq("stall_burst_held", 32'(burst2), 32'h1);
    tick();
    check_eq("stall_move", 32'(grant2), 32'h2);
    check_eq("stall_burst0", 32'(burst2), 32'h0);

    // Release together with the quantum-ending fire: one rotation only
    req2 = 2'b11; fire2 = 1'b1;
    tick(); tick(); tick();
    check_eq("relq_burst3", 32'(burst2), 32'h3);
    rel2 = 1'b1;
    tick();
    rel2 = 1'b0;
    check_eq("relq_grant", 32'(grant2), 32'h1);
    check_eq("relq_burst", 32'(burst2), 32'h0);
    tick();
    check_eq("relq_after", 32'(grant2), 32'h1);
    check_eq("relq_after_b", 32'(burst2), 32'h1);

    // 3-flux early release
    req3 = 3'b010;
    tick();
    check_eq("f3_grant1", 32'(grant3), 32'h2);
    req3 = 3'b111; fire3 = 1'b1;
    tick(); tick();
    check_eq("f3_burst2", 32'(burst3), 32'h2);
    fire3 = 1'b0; rel3 = 1'b1;
    tick();
    check_eq("f3_rel_tag2", 32'(tag3), 32'h2);
    check_eq("f3_rel_grant", 32'(grant3), 32'h4);
    check_eq("f3_rel_burst", 32'(burst3), 32'h0);
    tick();
    check_eq("f3_rot_tag0", 32'(tag3), 32'h0);
    tick();
    check_eq("f3_rot_tag1", 32'(tag3), 32'h1);
    req3 = 3'b000;
    tick();
    rel3 = 1'b0;
    check_eq("f3_idle_grant", 32'(grant3), 32'h0);
    check_eq("f3_idle_gv",    32'(gv3),    32'h0);
    check_eq("f3_idle_tag",   32'(tag3),   32'h1);
    req3 = 3'b100;
    tick();
    check_eq("f3_regrant", 32'(grant3), 32'h4);
    check_eq("f3_regrant_gv", 32'(gv3), 32'h1);

    // Async reset mid-burst on flux0 (burst currently 1)
    req2 = 2'b11; fire2 = 1'b1;
    tick(); tick();
    check_eq("arst_pre_burst", 32'(burst2), 32'h3);
    check_eq("arst_pre_grant", 32'(grant2), 32'h1);
    #2 rst = 1'b1;
    #2;
    check_eq("arst_grant", 32'(grant2), 32'h0);
    check_eq("arst_gv",    32'(gv2),    32'h0);
    check_eq("arst_burst", 32'(burst2), 32'h0);
    fire2 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("arst_regrant", 32'(grant2), 32'h1);
    check_eq("arst_retag",   32'(tag2),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
